// File: rtl/divider_seq.sv
// Unsigned restoring divider: one quotient bit per cycle behind a start/busy/done handshake.
// Results are registered only on completion, so callers never see partial values.
module divider_seq #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_data1,
   input  logic [WIDTH-1:0] i_data2,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_divisor;
   logic             r_zero;

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_fits;
   logic             w_accept;

   // The extra remainder bit keeps the carry when the divisor's MSB is set.
   assign w_shift  = {r_rem, r_q[WIDTH-1]};
   assign w_trial  = w_shift - {2'b00, r_divisor};
   assign w_fits   = ~w_trial[WIDTH+1];
   assign w_accept = i_start && (r_state != S_CALC);

   // A zero divisor skips the iterations (counter starts at 0); r_q then still holds the dividend.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_count       <= '0;
         r_rem         <= '0;
         r_q           <= '0;
         r_divisor     <= '0;
         r_zero        <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            S_CALC: begin
               if (r_count != '0) begin
                  r_q     <= {r_q[WIDTH-2:0], w_fits};
                  r_rem   <= w_fits ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
                  r_count <= r_count - 1'b1;
               end else begin
                  r_state <= S_FIN;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  if (r_zero) begin
                     o_quotient    <= '1;
                     o_remainder   <= r_q;
                     o_div_by_zero <= 1'b1;
                  end else begin
                     o_quotient    <= r_q;
                     o_remainder   <= r_rem[WIDTH-1:0];
                     o_div_by_zero <= 1'b0;
                  end
               end
            end
            default: begin
               o_done <= 1'b0;
               if (w_accept) begin
                  r_state   <= S_CALC;
                  r_rem     <= '0;
                  r_q       <= i_data1;
                  r_divisor <= i_data2;
                  r_zero    <= (i_data2 == '0);
                  r_count   <= (i_data2 == '0) ? '0 : CW'(WIDTH);
                  o_busy    <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed vector table, hand-written handshake corner cases,
// and random divisions compared against plain-arithmetic division.
module tb_divider_seq;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] d1 = '0;
   logic [WIDTH-1:0] d2 = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             dbz;

   int total = 0;
   int bad = 0;

   logic [WIDTH-1:0] prevQ = '0;
   logic [WIDTH-1:0] prevR = '0;
   logic             prevZ = 1'b0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             z;
   } vec_t;

   vec_t vecs[7];

   divider_seq #(.WIDTH(WIDTH)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_start(start),
      .i_data1(d1),
      .i_data2(d2),
      .o_busy(busy),
      .o_done(done),
      .o_quotient(quo),
      .o_remainder(rem),
      .o_div_by_zero(dbz)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                  output logic z);
      if (b == 0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   // Called at the negedge just after the accepting edge; counts cycles until done,
   // checking busy and that the previous result is held meanwhile.
   task automatic waitDone(input int pokeAt, output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         checkOutput("busyWhileCalc", busy, 1);
         checkOutput("holdQ", quo, prevQ);
         checkOutput("holdR", rem, prevR);
         checkOutput("holdZ", dbz, prevZ);
         if (lat == pokeAt) begin
            start = 1'b1;
            d1 = 8'd50;
            d2 = 8'd5;
         end else if (pokeAt >= 0 && lat == pokeAt + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic checkResult(input string name, input int lat, input int expLat,
                              input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic z);
      checkOutput({name, "_latency"}, lat, expLat);
      checkOutput({name, "_done"}, done, 1);
      checkOutput({name, "_busyLow"}, busy, 0);
      checkOutput({name, "_q"}, quo, q);
      checkOutput({name, "_r"}, rem, r);
      checkOutput({name, "_dbz"}, dbz, z);
      prevQ = q;
      prevR = r;
      prevZ = z;
   endtask

   task automatic applyStimulus(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic z,
                                input int pokeAt);
      int lat;
      @(negedge clk);
      start = 1'b1;
      d1 = a;
      d2 = b;
      @(negedge clk);
      start = 1'b0;
      d1 = WIDTH'($urandom);
      d2 = WIDTH'($urandom);
      waitDone(pokeAt, lat);
      checkResult(name, lat, (b == 0) ? 1 : WIDTH + 1, q, r, z);
      @(negedge clk);
      checkOutput({name, "_donePulse"}, done, 0);
   endtask

   initial begin
      int lat;
      int seen;
      logic [WIDTH-1:0] a, b, q, r;
      logic z;

      vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
      vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
      vecs[2] = '{a: 8'd3,   b: 8'd200, q: 8'd0,   r: 8'd3,   z: 1'b0};
      vecs[3] = '{a: 8'd200, b: 8'd200, q: 8'd1,   r: 8'd0,   z: 1'b0};
      vecs[4] = '{a: 8'd255, b: 8'd128, q: 8'd1,   r: 8'd127, z: 1'b0};
      vecs[5] = '{a: 8'd5,   b: 8'd0,   q: 8'd255, r: 8'd5,   z: 1'b1};
      vecs[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   z: 1'b0};

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_q", quo, 0);
      checkOutput("rst_r", rem, 0);
      checkOutput("rst_dbz", dbz, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1);
      end

      // START pulsed mid-calculation with other operands must be ignored.
      applyStimulus("ignoreStart", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 3);

      // START held through FIN: second request accepted on the FIN edge.
      @(negedge clk);
      start = 1'b1;
      d1 = 8'd60;
      d2 = 8'd7;
      @(negedge clk);
      d1 = 8'd81;
      d2 = 8'd9;
      waitDone(-1, lat);
      checkResult("b2b_first", lat, WIDTH + 1, 8'd8, 8'd4, 1'b0);
      @(negedge clk);
      checkOutput("b2b_doneDrop", done, 0);
      checkOutput("b2b_busyRise", busy, 1);
      start = 1'b0;
      waitDone(-1, lat);
      checkResult("b2b_second", lat, WIDTH + 1, 8'd9, 8'd0, 1'b0);
      @(negedge clk);
      checkOutput("b2b_donePulse", done, 0);

      // Asynchronous reset during a calculation.
      @(negedge clk);
      start = 1'b1;
      d1 = 8'd100;
      d2 = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_q", quo, 0);
      checkOutput("abort_r", rem, 0);
      checkOutput("abort_dbz", dbz, 0);
      prevQ = '0;
      prevR = '0;
      prevZ = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      checkOutput("abort_quiet", seen, 0);
      applyStimulus("afterAbort", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, -1);

      for (int i = 0; i < 40; i++) begin
         a = WIDTH'($urandom_range(0, 255));
         case ($urandom_range(0, 4))
            0:       b = '0;
            1:       b = WIDTH'($urandom_range(128, 255));
            default: b = WIDTH'($urandom_range(1, 255));
         endcase
         refDiv(a, b, q, r, z);
         applyStimulus($sformatf("rand%0d_%0d_%0d", i, a, b), a, b, q, r, z, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
